// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM state encoding, default parameters and the grant-index width helper.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_CYC = 100000;

    // Width of a requester index; never less than one bit.
    function automatic int gid_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from i_last+1 with wrap to 0 and returns the first active requester.
module uart_rr_pick
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [gid_w(NUM_REQ)-1:0] i_last,
    output logic [gid_w(NUM_REQ)-1:0] o_win,
    output logic                      o_vld
);
    localparam int GW = gid_w(NUM_REQ);

    logic [GW-1:0] w_hi;
    logic [GW-1:0] w_lo;
    logic          w_hi_vld;
    logic          w_lo_vld;

    // Two priority groups: lowest index above i_last first, else lowest index overall (the wrap).
    // The loop runs downward so the last hit, i.e. the lowest index, wins.
    always_comb begin
        w_hi     = '0;
        w_lo     = '0;
        w_hi_vld = 1'b0;
        w_lo_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_vld = 1'b1;
                w_lo     = GW'(i);
                if (GW'(i) > i_last) begin
                    w_hi_vld = 1'b1;
                    w_hi     = GW'(i);
                end
            end
        end
        o_vld = w_lo_vld;
        o_win = w_hi_vld ? w_hi : w_lo;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte transmitter among NUM_REQ requesters.
// IDLE picks a winner and pulses gnt, SEND pulses tx_send_en, WAIT holds until tx_done.
// Optional WAIT watchdog: define UART_ARB_TIMEOUT_EN to build it (timeout_err tied 0 otherwise).
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [8*NUM_REQ-1:0]      req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [7:0]                tx_data_byte,
    output logic                      tx_send_en,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [gid_w(NUM_REQ)-1:0] grant_id,
    output logic                      timeout_err
);
    localparam int GW = gid_w(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("uart_tx_arbiter: NUM_REQ must be 2..8");
        end
        if (TIMEOUT_CYC < 2) begin : g_bad_timeout
            $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 2");
        end
    endgenerate

    arb_state_e                r_state, w_state_nxt;
    logic [NUM_REQ-1:0]        r_gnt, w_gnt;
    logic                      r_send, w_send;
    logic [7:0]                r_data, w_data;
    logic [GW-1:0]             r_gid, w_gid;
    logic [GW-1:0]             r_last, w_last;
    logic [GW-1:0]             w_pick;
    logic                      w_pick_vld;
    logic [NUM_REQ-1:0][7:0]   w_bytes;

    assign w_bytes = req_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] r_wdog, w_wdog;
    logic          r_tmo, w_tmo;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req  (req),
        .i_last (r_last),
        .o_win  (w_pick),
        .o_vld  (w_pick_vld)
    );

    // Next state and next registered outputs; pulses default low, data/ids hold.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_send      = 1'b0;
        w_data      = r_data;
        w_gid       = r_gid;
        w_last      = r_last;
`ifdef UART_ARB_TIMEOUT_EN
        w_wdog      = r_wdog;
        w_tmo       = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_gnt       = NUM_REQ'(1) << w_pick;
                    w_data      = w_bytes[w_pick];
                    w_gid       = w_pick;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // Registered, so the start pulse follows gnt by one cycle and never overlaps it.
                w_send      = 1'b1;
                w_state_nxt = ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                w_wdog      = '0;
`endif
            end
            ST_WAIT: begin
                // Returning to IDLE first guarantees at least one idle cycle between bytes.
                if (tx_done) begin
                    w_last      = r_gid;
                    w_state_nxt = ST_IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (r_wdog == CW'(TIMEOUT_CYC - 1)) begin
                    w_tmo       = 1'b1;
                    w_last      = r_gid;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wdog = r_wdog + 1'b1;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset; last_grant resets so requester 0 wins first.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_send  <= 1'b0;
            r_data  <= '0;
            r_gid   <= '0;
            r_last  <= GW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            r_wdog  <= '0;
            r_tmo   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt;
            r_send  <= w_send;
            r_data  <= w_data;
            r_gid   <= w_gid;
            r_last  <= w_last;
`ifdef UART_ARB_TIMEOUT_EN
            r_wdog  <= w_wdog;
            r_tmo   <= w_tmo;
`endif
        end
    end

    assign gnt          = r_gnt;
    assign tx_send_en   = r_send;
    assign tx_data_byte = r_data;
    assign grant_id     = r_gid;
    assign busy         = (r_state != ST_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err  = r_tmo;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule
